// File: rtl/soc_mbox_master.sv
// soc_mbox_master: single-outstanding host-command master for a 4-word
// Avalon-MM single-port mailbox RAM (unregistered read data, clock enable).
// Optional autonomous poller compiled in with `define SOC_MBOX_POLL_EN:
// it periodically reads POLL_ADDR and pulses doorbell on a nonzero word.
module soc_mbox_master #(
  parameter int unsigned POLL_PERIOD = 256,
  parameter logic [1:0]  POLL_ADDR   = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_addr,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  address,
  output logic [3:0]  byteenable,
  output logic        chipselect,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        clken,
  output logic        doorbell,
  output logic [31:0] doorbell_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

  state_t state, state_nx;
  logic   wr_q;       // current transaction is a write
  logic   is_poll;    // current transaction is an internal poll read
  logic   accept;
  logic   poll_issue;

`ifdef SOC_MBOX_POLL_EN
  logic [15:0] poll_cnt;
  logic        poll_pend;
  logic        poll_hit;

  assign poll_hit   = (poll_cnt == 16'(POLL_PERIOD - 1));
  // A host command presented in the same cycle takes precedence; the poll
  // is remembered in poll_pend and issues on a later idle cycle.
  assign poll_issue = (state == IDLE) && !reset && !cmd_valid && (poll_hit || poll_pend);

  // Poll counter, pending flag and doorbell capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt      <= '0;
      poll_pend     <= 1'b0;
      doorbell      <= 1'b0;
      doorbell_data <= '0;
    end else begin
      poll_cnt <= poll_issue ? '0 : poll_cnt + 16'd1;
      if (poll_issue)
        poll_pend <= 1'b0;
      else if (poll_hit)
        poll_pend <= 1'b1;
      doorbell <= 1'b0;
      if ((state == RDWAIT) && clken && is_poll && (readdata != '0)) begin
        doorbell      <= 1'b1;
        doorbell_data <= readdata;
      end
    end
  end
`else
  assign poll_issue    = 1'b0;
  assign doorbell      = 1'b0;
  assign doorbell_data = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic and state-decoded handshake / bus strobes.
  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !reset;
        accept    = cmd_valid && !reset;
        if (accept || poll_issue)
          state_nx = ACCESS;
      end
      ACCESS: begin
        chipselect = !reset;
        write      = !reset && wr_q;
        if (clken)
          state_nx = wr_q ? RESP : RDWAIT;
      end
      RDWAIT: begin
        if (clken)
          state_nx = is_poll ? IDLE : RESP;
      end
      RESP: begin
        rsp_valid = !reset;
        if (rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transaction registers: bus address/data and response payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= 1'b0;
      is_poll    <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      if (accept) begin
        wr_q       <= cmd_write;
        is_poll    <= 1'b0;
        address    <= cmd_addr;
        byteenable <= cmd_write ? cmd_be : 4'hF;
        writedata  <= cmd_wdata;
        rsp_write  <= cmd_write;
      end else if (poll_issue) begin
        wr_q       <= 1'b0;
        is_poll    <= 1'b1;
        address    <= POLL_ADDR;
        byteenable <= 4'hF;
        writedata  <= '0;
      end
      if ((state == ACCESS) && clken && wr_q)
        rsp_rdata <= '0;
      if ((state == RDWAIT) && clken && !is_poll)
        rsp_rdata <= readdata;
    end
  end

endmodule
